// File: rtl/avalon_mm_csr_slave_if.sv
// Avalon-MM command/response bundle between a CSR master and the register bank.
// Handshake: no waitrequest; read/write are accepted in the cycle they are high,
// and each accepted read returns exactly one readdatavalid pulse, in order.
interface avalon_mm_csr_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_mm_csr_slave.sv
// Avalon-MM CSR bank: ID, CTRL, sticky W1C STATUS, scratch registers, pipelined reads.
// Define AVMM_CSR_CYCLE_CNT_EN to add the free-running CYCLE_CNT register at address 3.
module avalon_mm_csr_slave #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          READ_LATENCY = 2,
    parameter int          NUM_SCRATCH  = 4,
    parameter logic [31:0] ID_VALUE     = 32'hC0DE_0001
) (
    input  logic                              clk,
    input  logic                              rst,
    avalon_mm_csr_slave_if.slave              bus,
    input  logic                              event_in,
    output logic [DATA_WIDTH-1:0]             ctrl_out
);
    localparam logic [DATA_WIDTH-1:0] ID_WORD   = DATA_WIDTH'(ID_VALUE);
    localparam logic [DATA_WIDTH-1:0] DEAD_WORD = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [DATA_WIDTH-1:0] ctrl;
    logic [2:0]            status;
    logic [DATA_WIDTH-1:0] scratch   [NUM_SCRATCH];
    logic                  pipe_valid[READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];

    logic [DATA_WIDTH-1:0] rd_now;
    logic                  mapped;
    logic                  accept_read;
    logic [2:0]            status_set;
    logic [2:0]            status_clr;

`ifdef AVMM_CSR_CYCLE_CNT_EN
    logic [DATA_WIDTH-1:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_now = '0;
        mapped = 1'b0;
        if (bus.address == ADDR_WIDTH'(0)) begin
            rd_now = ID_WORD;
            mapped = 1'b1;
        end
        if (bus.address == ADDR_WIDTH'(1)) begin
            rd_now = ctrl;
            mapped = 1'b1;
        end
        if (bus.address == ADDR_WIDTH'(2)) begin
            rd_now = {{(DATA_WIDTH-3){1'b0}}, status};
            mapped = 1'b1;
        end
`ifdef AVMM_CSR_CYCLE_CNT_EN
        if (bus.address == ADDR_WIDTH'(3)) begin
            rd_now = cycle_cnt;
            mapped = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (bus.address == ADDR_WIDTH'(4 + i)) begin
                rd_now = scratch[i];
                mapped = 1'b1;
            end
        end
        if (!mapped) begin
            rd_now = DEAD_WORD;
        end
    end

    // A simultaneous write wins; the read is dropped and flagged as a protocol error.
    assign accept_read = bus.read && !bus.write;
    assign status_set  = {(bus.read || bus.write) && !mapped, bus.read && bus.write, event_in};
    assign status_clr  = (bus.write && bus.address == ADDR_WIDTH'(2)) ? bus.writedata[2:0] : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl   <= '0;
            status <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            if (bus.write) begin
                if (bus.address == ADDR_WIDTH'(1)) begin
                    ctrl <= bus.writedata;
                end
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (bus.address == ADDR_WIDTH'(4 + i)) begin
                        scratch[i] <= bus.writedata;
                    end
                end
            end
            // Set has priority over a same-cycle write-1-to-clear.
            status <= (status & ~status_clr) | status_set;

            // Data is zeroed at entry so readdata is 0 whenever the pulse is low.
            pipe_valid[0] <= accept_read;
            pipe_data[0]  <= accept_read ? rd_now : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.readdata      = pipe_data[READ_LATENCY-1];
    assign bus.readdatavalid = pipe_valid[READ_LATENCY-1];
    assign ctrl_out          = ctrl;
endmodule

// File: tb/tb_avalon_mm_csr_slave.sv
// Directed bench for avalon_mm_csr_slave with a latency-aware read scoreboard.
// Follows AVMM_CSR_CYCLE_CNT_EN the same way the design does.
module tb_avalon_mm_csr_slave;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        event_in = 1'b0;
    logic [31:0] ctrl_out;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];
    bit          care_q[$];
    logic [31:0] cap_q[$];

    avalon_mm_csr_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus();

    avalon_mm_csr_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(LAT),
        .NUM_SCRATCH(4), .ID_VALUE(32'hC0DE_0001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .event_in(event_in),
        .ctrl_out(ctrl_out)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] e;
        int          d;
        bit          c;
        if (bus.readdatavalid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_valid got readdata=%h with no read outstanding", bus.readdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                c = care_q.pop_front();
                checks++;
                assert (cyc === d) else begin
                    fails++;
                    $error("FAIL read_latency valid at cycle %0d, required cycle %0d", cyc, d);
                end
                if (c) begin
                    checks++;
                    assert (bus.readdata === e) else begin
                        fails++;
                        $error("FAIL readdata got %h, required %h", bus.readdata, e);
                    end
                end else begin
                    cap_q.push_back(bus.readdata);
                end
            end
        end else begin
            checks++;
            assert (bus.readdata === 32'h0) else begin
                fails++;
                $error("FAIL idle_readdata got %h, required 0", bus.readdata);
            end
            if (due_q.size() != 0) begin
                checks++;
                assert (due_q[0] > cyc) else begin
                    fails++;
                    $error("FAIL missing_valid no pulse at cycle %0d, required by cycle %0d", cyc, due_q[0]);
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    void'(care_q.pop_front());
                end
            end
        end
    end

    // driver tasks (called at a falling edge, return at the next falling edge)
    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input bit care = 1'b1);
        bus.address = a;
        bus.read    = 1'b1;
        exp_q.push_back(e);
        due_q.push_back(cyc + LAT);
        care_q.push_back(care);
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic do_rw(input logic [31:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s got %h, required %h", tag, got, req);
        end
    endtask

    task automatic drain;
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout %0d reads outstanding, required 0", exp_q.size());
            exp_q.delete(); due_q.delete(); care_q.delete();
        end
    endtask

    initial begin
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        idle(3);
        check_val("reset_ctrl_out", ctrl_out, 32'h0);
        check_val("reset_valid", {31'h0, bus.readdatavalid}, 32'h0);
        rst = 1'b0;
        idle(1);

        // ID read and ignored ID write
        do_read(32'd0, 32'hC0DE_0001);
        idle(3);
        do_write(32'd0, 32'hFFFF_FFFF);
        do_read(32'd0, 32'hC0DE_0001);

        // scratch write/read and back-to-back reads
        do_write(32'd6, 32'h1234_5678);
        do_read(32'd6, 32'h1234_5678);
        do_write(32'd4, 32'hAAAA_0004);
        do_write(32'd5, 32'hBBBB_0005);
        do_write(32'd7, 32'hDDDD_0007);
        do_read(32'd4, 32'hAAAA_0004);
        do_read(32'd5, 32'hBBBB_0005);
        do_read(32'd6, 32'h1234_5678);
        do_read(32'd7, 32'hDDDD_0007);
        drain();

        // sticky event, set beats clear, then clear
        event_in = 1'b1;
        idle(1);
        event_in = 1'b0;
        do_read(32'd2, 32'h1);
        event_in = 1'b1;
        do_write(32'd2, 32'h1);
        event_in = 1'b0;
        do_read(32'd2, 32'h1);
        do_write(32'd2, 32'h1);
        do_read(32'd2, 32'h0);
        drain();

        // read+write collision: write done, read dropped, STATUS[1]
        do_rw(32'd1, 32'h5);
        check_val("collision_ctrl_out", ctrl_out, 32'h5);
        do_read(32'd1, 32'h5);
        do_read(32'd2, 32'h2);
        do_write(32'd2, 32'h7);
        drain();

        // unmapped read and write
        do_read(32'd100, 32'hDEAD_BEEF);
        do_read(32'd2, 32'h4);
        do_write(32'd2, 32'h7);
        do_write(32'd200, 32'h1);
        do_read(32'd2, 32'h4);
        do_write(32'd2, 32'h7);
        do_read(32'd2, 32'h0);
        drain();

`ifdef AVMM_CSR_CYCLE_CNT_EN
        do_read(32'd3, 32'h0, 1'b0);
        idle(9);
        do_read(32'd3, 32'h0, 1'b0);
        do_read(32'd2, 32'h0);
        drain();
        checks++;
        assert (cap_q.size() == 2) else begin
            fails++;
            $error("FAIL cycle_cnt_captures got %0d, required 2", cap_q.size());
        end
        if (cap_q.size() == 2) check_val("cycle_cnt_delta", cap_q[1] - cap_q[0], 32'd10);
`else
        do_read(32'd3, 32'hDEAD_BEEF);
        do_read(32'd2, 32'h4);
        do_write(32'd2, 32'h7);
        drain();
`endif

        // reset with a read in flight
        do_write(32'd1, 32'h55);
        do_write(32'd4, 32'h99);
        event_in = 1'b1;
        do_read(32'd1, 32'h55);
        event_in = 1'b0;
        rst = 1'b1;
        exp_q.delete(); due_q.delete(); care_q.delete();
        idle(3);
        check_val("rst_ctrl_out", ctrl_out, 32'h0);
        rst = 1'b0;
        idle(2);
        check_val("post_rst_ctrl_out", ctrl_out, 32'h0);
        do_read(32'd1, 32'h0);
        do_read(32'd2, 32'h0);
        do_read(32'd4, 32'h0);
        do_read(32'd0, 32'hC0DE_0001);
        drain();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
